// File: rtl/sdram_burst_sched.sv
// +----------------------------------------------------------------------------+
// | Module      : sdram_burst_sched                                            |
// | Description : Shares the sdram_top burst port between the write path and   |
// |               the read path. It issues one row burst at a time and advances|
// |               the frame row pointers. Define SCHED_PINGPONG_EN to enable   |
// |               double buffering across banks 0 and 1.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module sdram_burst_sched #(
  parameter int FRAME_ROWS = 128,
  parameter int WR_THRESH  = 512,
  parameter int RD_THRESH  = 512,
  parameter int RD_URGENT  = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] wr_fifo_used,
  input  logic [10:0] rd_fifo_used,
  input  logic        frame_start,
  output logic        wr_sdram_req,
  input  logic        wr_sdram_ack,
  output logic [23:0] wr_sdram_add,
  output logic        rd_sdram_req,
  input  logic        rd_sdram_ack,
  output logic [23:0] rd_sdram_add,
  output logic        frame_valid,
  output logic        busy
);

  localparam int                 c_row_w     = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;
  localparam logic [c_row_w-1:0] c_last_row  = c_row_w'(FRAME_ROWS - 1);
  localparam logic [10:0]        c_wr_thresh = 11'(WR_THRESH);
  localparam logic [10:0]        c_rd_thresh = 11'(RD_THRESH);
  localparam logic [10:0]        c_rd_urgent = 11'(RD_URGENT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_BUSY = 2'd1,
    S_RD_BUSY = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_row_w-1:0] r_wr_row;
  logic [c_row_w-1:0] r_rd_row;
  logic               r_rd_done;
  logic               r_restart_pend;
  logic               r_last_rd;
  logic               r_frame_valid;

  logic               w_wr_elig;
  logic               w_rd_elig;
  logic               w_grant_wr;
  logic               w_grant_rd;
  logic               w_wr_ack;
  logic               w_rd_ack;
  logic               w_wr_wrap;
  logic               w_rd_reload;
  logic [1:0]         w_wr_bank;
  logic [1:0]         w_rd_bank;

  assign w_wr_elig  = (wr_fifo_used >= c_wr_thresh);
  assign w_rd_elig  = r_frame_valid && !r_rd_done && (rd_fifo_used <= c_rd_thresh);
  // Contested grants go to the side that lost last time unless the read FIFO is nearly dry
  assign w_grant_rd = w_rd_elig && (!w_wr_elig || (rd_fifo_used < c_rd_urgent) || !r_last_rd);
  assign w_grant_wr = w_wr_elig && !w_grant_rd;

  assign w_wr_ack    = (r_state == S_WR_BUSY) && wr_sdram_ack;
  assign w_rd_ack    = (r_state == S_RD_BUSY) && rd_sdram_ack;
  assign w_wr_wrap   = w_wr_ack && (r_wr_row == c_last_row);
  assign w_rd_reload = w_rd_ack ? (r_restart_pend || frame_start)
                                : (frame_start && (r_state != S_RD_BUSY));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    wr_sdram_req = 1'b0;
    rd_sdram_req = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_rd)      w_state_nxt = S_RD_BUSY;
        else if (w_grant_wr) w_state_nxt = S_WR_BUSY;
      end
      S_WR_BUSY: begin
        wr_sdram_req = 1'b1;
        busy         = 1'b1;
        if (wr_sdram_ack) w_state_nxt = S_IDLE;
      end
      S_RD_BUSY: begin
        rd_sdram_req = 1'b1;
        busy         = 1'b1;
        if (rd_sdram_ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_row       <= '0;
      r_rd_row       <= '0;
      r_rd_done      <= 1'b0;
      r_restart_pend <= 1'b0;
      r_last_rd      <= 1'b0;
      r_frame_valid  <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && (w_grant_rd || w_grant_wr)) r_last_rd <= w_grant_rd;

      if (w_wr_ack) begin
        r_wr_row <= w_wr_wrap ? '0 : r_wr_row + 1'b1;
        if (w_wr_wrap) r_frame_valid <= 1'b1;
      end

      // A frame start during a read burst waits for that burst's ack
      if (w_rd_reload) begin
        r_rd_row       <= '0;
        r_rd_done      <= 1'b0;
        r_restart_pend <= 1'b0;
      end else if (w_rd_ack) begin
        if (r_rd_row == c_last_row) r_rd_done <= 1'b1;
        else                        r_rd_row  <= r_rd_row + 1'b1;
      end else if (frame_start && (r_state == S_RD_BUSY)) begin
        r_restart_pend <= 1'b1;
      end
    end
  end

`ifdef SCHED_PINGPONG_EN
  logic r_wr_bank;
  logic r_rd_bank;
  logic r_done_bank;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_done_bank <= 1'b0;
    end else begin
      if (w_wr_wrap) begin
        r_wr_bank   <= ~r_wr_bank;
        r_done_bank <= r_wr_bank;
      end
      if (w_rd_reload) r_rd_bank <= r_done_bank;
    end
  end

  assign w_wr_bank = {1'b0, r_wr_bank};
  assign w_rd_bank = {1'b0, r_rd_bank};
`else
  assign w_wr_bank = 2'b00;
  assign w_rd_bank = 2'b00;
`endif

  assign wr_sdram_add = {w_wr_bank, 13'(r_wr_row), 9'd0};
  assign rd_sdram_add = {w_rd_bank, 13'(r_rd_row), 9'd0};
  assign frame_valid  = r_frame_valid;

endmodule

`default_nettype wire

// File: tb/tb_sdram_burst_sched.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_sdram_burst_sched                                         |
// | Description : Scoreboard bench for sdram_burst_sched; expected grants are  |
// |               queued by the stimulus and popped by a monitor on each req.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sdram_burst_sched;

`ifdef SCHED_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif
  localparam logic [1:0] WB2 = PP ? 2'd1 : 2'd0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] wr_fifo_used;
  logic [10:0] rd_fifo_used;
  logic        frame_start;
  logic        wr_sdram_req;
  logic        wr_sdram_ack;
  logic [23:0] wr_sdram_add;
  logic        rd_sdram_req;
  logic        rd_sdram_ack;
  logic [23:0] rd_sdram_add;
  logic        frame_valid;
  logic        busy;

  int          errors   = 0;
  int          checks   = 0;
  int          n_grants = 0;
  logic [24:0] exp_q[$];
  logic        prev_wr  = 1'b0;
  logic        prev_rd  = 1'b0;
  logic [24:0] exp_e;

  sdram_burst_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_fifo_used (wr_fifo_used),
    .rd_fifo_used (rd_fifo_used),
    .frame_start  (frame_start),
    .wr_sdram_req (wr_sdram_req),
    .wr_sdram_ack (wr_sdram_ack),
    .wr_sdram_add (wr_sdram_add),
    .rd_sdram_req (rd_sdram_req),
    .rd_sdram_ack (rd_sdram_ack),
    .rd_sdram_add (rd_sdram_add),
    .frame_valid  (frame_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk_addr(input logic [1:0] bank, input int row);
    return {bank, 13'(row), 9'd0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit rd, input logic [1:0] bank, input int row);
    exp_q.push_back({rd, mk_addr(bank, row)});
  endtask

  task automatic wait_grants(input int target);
    int b = 0;
    while (n_grants < target && b < 4000) begin
      @(negedge clk);
      b++;
    end
    if (n_grants < target) check("grant_timeout", n_grants, target);
  endtask

  task automatic wait_idle();
    int b = 0;
    while (busy && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (busy) check("idle_timeout", {31'd0, busy}, 0);
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // Memory model: ack three cycles after a request is first seen
  initial begin
    wr_sdram_ack = 1'b0;
    rd_sdram_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_sdram_req || rd_sdram_req) begin
        automatic bit side_rd = rd_sdram_req;
        repeat (3) @(negedge clk);
        if (side_rd) rd_sdram_ack = 1'b1;
        else         wr_sdram_ack = 1'b1;
        @(negedge clk);
        wr_sdram_ack = 1'b0;
        rd_sdram_ack = 1'b0;
      end
    end
  end

  // Monitor: every new request is matched against the next queued expectation
  initial begin
    forever begin
      @(negedge clk);
      if ((wr_sdram_req && !prev_wr) || (rd_sdram_req && !prev_rd)) begin
        n_grants++;
        check("idle_before_grant", {29'd0, prev_wr, prev_rd, wr_sdram_req && rd_sdram_req}, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_grant", {31'd0, rd_sdram_req}, {31'd0, ~rd_sdram_req});
        end else begin
          exp_e = exp_q.pop_front();
          check("grant_kind", {31'd0, rd_sdram_req}, {31'd0, exp_e[24]});
          check("grant_addr", {8'd0, rd_sdram_req ? rd_sdram_add : wr_sdram_add}, {8'd0, exp_e[23:0]});
        end
      end
      prev_wr = wr_sdram_req;
      prev_rd = rd_sdram_req;
    end
  end

  initial begin
    rst_n        = 1'b0;
    wr_fifo_used = 11'd0;
    rd_fifo_used = 11'd0;
    frame_start  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_req", {31'd0, wr_sdram_req}, 0);
    check("rst_rd_req", {31'd0, rd_sdram_req}, 0);
    check("rst_wr_add", {8'd0, wr_sdram_add}, 0);
    check("rst_rd_add", {8'd0, rd_sdram_add}, 0);
    check("rst_frame_valid", {31'd0, frame_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);

    // First frame: 128 writes to bank 0, no reads before frame_valid
    for (int r = 0; r < 128; r++) push(1'b0, 2'd0, r);
    wr_fifo_used = 11'd512;
    rd_fifo_used = 11'd0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_grants(128);
    wr_fifo_used = 11'd0;
    rd_fifo_used = 11'd1000;
    check("fv_before_last_ack", {31'd0, frame_valid}, 0);
    wait_idle();
    check("fv_after_last_ack", {31'd0, frame_valid}, 1);

    // Both eligible, not urgent: strict alternation, read first after the write run
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 2'd0, i);
      push(1'b0, WB2, i);
    end
    rd_fifo_used = 11'd300;
    wr_fifo_used = 11'd600;
    wait_grants(134);
    wr_fifo_used = 11'd0;
    rd_fifo_used = 11'd1000;
    wait_idle();

    // Urgent read level: reads win every time
    for (int r = 3; r < 6; r++) push(1'b1, 2'd0, r);
    rd_fifo_used = 11'd100;
    wr_fifo_used = 11'd600;
    wait_grants(137);
    wr_fifo_used = 11'd0;
    rd_fifo_used = 11'd1000;
    wait_idle();

    // Finish the read frame; rd_done must block further reads
    for (int r = 6; r < 128; r++) push(1'b1, 2'd0, r);
    rd_fifo_used = 11'd100;
    wait_grants(259);
    wait_idle();
    repeat (20) @(negedge clk);
    check("rd_done_blocks", n_grants, 259);
    check("rd_done_idle", {31'd0, busy}, 0);

    // Frame start restarts at row 0; a start during the row-40 burst defers to its ack
    push(1'b1, 2'd0, 0);
    for (int r = 1; r <= 40; r++) push(1'b1, 2'd0, r);
    push(1'b1, 2'd0, 0);
    pulse_frame_start();
    wait_grants(300);
    pulse_frame_start();
    wait_grants(301);
    rd_fifo_used = 11'd1000;
    wait_idle();

    // Second write frame, then frame start selects the just-completed bank
    for (int r = 3; r < 128; r++) push(1'b0, WB2, r);
    wr_fifo_used = 11'd600;
    wait_grants(426);
    wr_fifo_used = 11'd0;
    wait_idle();
    pulse_frame_start();
    push(1'b1, WB2, 0);
    rd_fifo_used = 11'd100;
    wait_grants(427);
    rd_fifo_used = 11'd1000;
    wait_idle();

    // Reset in the middle of a write burst
    push(1'b0, 2'd0, 0);
    wr_fifo_used = 11'd600;
    wait_grants(428);
    rst_n        = 1'b0;
    wr_fifo_used = 11'd0;
    @(negedge clk);
    check("midrst_wr_req", {31'd0, wr_sdram_req}, 0);
    check("midrst_rd_req", {31'd0, rd_sdram_req}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_frame_valid", {31'd0, frame_valid}, 0);
    check("midrst_wr_add", {8'd0, wr_sdram_add}, 0);
    check("midrst_rd_add", {8'd0, rd_sdram_add}, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
